// File: rtl/cac_fns_codec_9.sv
// rtl/cac_fns_codec_9.sv - FNS crosstalk-avoidance codec: registered encoder, combinational decoder
// Defining CAC_CODE_CHK_EN adds the code_err output and its codeword checker.
module cac_fns_codec_9 #(
  parameter int DATA_W = 6,
  parameter int TSV_W  = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  output logic [TSV_W-1:0]  tsv,
  input  logic [TSV_W-1:0]  tsv_in,
`ifdef CAC_CODE_CHK_EN
  output logic [DATA_W-1:0] dataout,
  output logic              code_err
`else
  output logic [DATA_W-1:0] dataout
`endif
);

`ifdef CAC_CODE_CHK_EN
  localparam int RANK_W = DATA_W + 1;
`else
  localparam int RANK_W = DATA_W;
`endif

  // Valid words below 2^j: the weight of a 1 at position j.
  function automatic logic [5:0] f_weight(input int j);
    case (j)
      0:       f_weight = 6'd1;
      1, 2:    f_weight = 6'd2;
      3, 4:    f_weight = 6'd5;
      5, 6:    f_weight = 6'd13;
      default: f_weight = 6'd34;
    endcase
  endfunction

  logic [TSV_W:0]     w_enc_ext;
  logic [DATA_W-1:0]  w_enc_rem;
  logic [5:0]         w_enc_z;
  logic [TSV_W-1:0]   r_tsv;

  // Greedy unranking: a 0 below an already-set odd wire is illegal, so its weight drops to 0.
  always_comb begin
    w_enc_ext = '0;
    w_enc_rem = datain;
    w_enc_z   = '0;
    for (int j = TSV_W - 1; j >= 0; j--) begin
      w_enc_z = f_weight(j);
      if ((j % 2 == 0) && w_enc_ext[j+1]) begin
        w_enc_z = '0;
      end
      if (w_enc_rem >= w_enc_z) begin
        w_enc_ext[j] = 1'b1;
        w_enc_rem    = w_enc_rem - w_enc_z;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tsv <= '0;
    end else begin
      r_tsv <= w_enc_ext[TSV_W-1:0];
    end
  end

  assign tsv = r_tsv;

  logic [TSV_W:0]     w_dec_ext;
  logic [TSV_W-1:0]   w_odd_ok;
  logic               w_pfx_ok;
  logic               w_zero_ok;
  logic [RANK_W-1:0]  w_rank;

  assign w_dec_ext = {1'b0, tsv_in};

  always_comb begin
    w_odd_ok = '1;
    for (int i = 1; i < TSV_W - 1; i += 2) begin
      w_odd_ok[i] = ~tsv_in[i] | (tsv_in[i-1] & tsv_in[i+1]);
    end
  end

  // Exact count of valid words below tsv_in, also for invalid inputs: a set bit j
  // contributes only if the bits above it, with bit j cleared, can still be valid.
  always_comb begin
    w_rank    = '0;
    w_pfx_ok  = 1'b1;
    w_zero_ok = 1'b1;
    for (int j = 0; j < TSV_W; j++) begin
      w_pfx_ok = 1'b1;
      for (int i = j + 2; i < TSV_W; i++) begin
        if (!w_odd_ok[i]) begin
          w_pfx_ok = 1'b0;
        end
      end
      w_zero_ok = !((j % 2 == 0) && w_dec_ext[j+1]);
      if (tsv_in[j] && w_pfx_ok && w_zero_ok) begin
        w_rank = w_rank + RANK_W'(f_weight(j));
      end
    end
  end

  assign dataout = w_rank[DATA_W-1:0];

`ifdef CAC_CODE_CHK_EN
  assign code_err = ~&w_odd_ok | w_rank[DATA_W];
`endif

endmodule

// File: tb/tb_cac_fns_codec_9.sv
// tb/tb_cac_fns_codec_9.sv - directed self-checking bench for cac_fns_codec_9
// Code-error checks are compiled in when CAC_CODE_CHK_EN is defined.
module tb_cac_fns_codec_9;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] datain;
  logic [8:0] tsv;
  logic [8:0] tsv_in;
  logic [8:0] tsv_drv;
  logic [5:0] dataout;
  bit         loop;
`ifdef CAC_CODE_CHK_EN
  logic       code_err;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] cw_tab [0:88];
  int n_valid = 0;

  logic [5:0] fx_d [8] = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd13, 6'd34, 6'd63};
  logic [8:0] fx_c [8] = '{9'b000000000, 9'b000000001, 9'b000000100, 9'b000000111,
                           9'b000010000, 9'b001000000, 9'b100000000, 9'b101110101};

  always #5 clock = ~clock;

  assign tsv_in = loop ? tsv : tsv_drv;

  cac_fns_codec_9 dut (
    .clock   (clock),
    .reset   (reset),
    .datain  (datain),
    .tsv     (tsv),
    .tsv_in  (tsv_in),
`ifdef CAC_CODE_CHK_EN
    .dataout (dataout),
    .code_err(code_err)
`else
    .dataout (dataout)
`endif
  );

  function automatic bit is_valid(input logic [8:0] w);
    for (int i = 1; i < 8; i += 2) begin
      if (w[i] && !(w[i-1] && w[i+1])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int rank_of(input logic [8:0] w);
    int cnt = 0;
    for (int i = 0; i < n_valid; i++) begin
      if (cw_tab[i] < w) cnt++;
    end
    return cnt;
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [8:0] prev;
    int exp_rank;

    for (int w = 0; w < 512; w++) begin
      if (is_valid(9'(w)) && n_valid < 89) begin
        cw_tab[n_valid] = 9'(w);
        n_valid++;
      end
    end

    loop    = 1'b0;
    tsv_drv = '0;
    reset   = 1'b1;
    datain  = 6'd37;
    #1;
    chk("rst_imm", tsv, 9'b000000000);
    repeat (2) begin
      tick();
      chk("rst_hold", tsv, 9'b000000000);
    end
    reset = 1'b0;
    tick();
    chk("rst_exit_cw37", tsv, 9'b100000101);

    for (int k = 0; k < 8; k++) begin
      datain = fx_d[k];
      tick();
      chk("fixed_cw", tsv, fx_c[k]);
    end

    datain = 6'd5;
    #2;
    chk("lat_hold", tsv, 9'b101110101);
    tick();
    chk("lat_update", tsv, 9'b000010000);

    tsv_drv = 9'b001000000;
    #1;
    chk("dec_comb_13", 9'(dataout), 9'd13);
    tsv_drv = 9'b100000000;
    #1;
    chk("dec_comb_34", 9'(dataout), 9'd34);

    loop = 1'b1;
    prev = '0;
    for (int k = 0; k < 64; k++) begin
      datain = 6'(k);
      tick();
      chk("sweep_cw", tsv, cw_tab[k]);
      chk("sweep_roundtrip", 9'(dataout), 9'(k));
      chk("sweep_valid", 9'(is_valid(tsv)), 9'd1);
      if (k > 0) chk("sweep_mono", 9'(tsv > prev), 9'd1);
      prev = tsv;
    end

    #2;
    reset = 1'b1;
    #1;
    chk("rst_async", tsv, 9'b000000000);
    chk("rst_async_dec", 9'(dataout), 9'd0);
    tick();
    reset = 1'b0;

    loop    = 1'b0;
    tsv_drv = 9'b000000010;
    #1;
    chk("inv_dec_002", 9'(dataout), 9'd2);
`ifdef CAC_CODE_CHK_EN
    chk("inv_err_002", 9'(code_err), 9'd1);
`endif
    tsv_drv = 9'b111111111;
    #1;
    chk("inv_dec_1ff", 9'(dataout), 9'd24);
`ifdef CAC_CODE_CHK_EN
    chk("inv_err_1ff", 9'(code_err), 9'd1);
`endif
    tsv_drv = 9'b010000001;
    #1;
    chk("inv_dec_081", 9'(dataout), 9'd34);

    for (int w = 0; w < 512; w++) begin
      tsv_drv = 9'(w);
      #1;
      exp_rank = rank_of(9'(w));
      chk("dec_all", 9'(dataout), 9'(exp_rank % 64));
`ifdef CAC_CODE_CHK_EN
      chk("err_all", 9'(code_err), 9'(!is_valid(9'(w)) || exp_rank > 63));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cac_fns_codec_9.md
Name: cac_fns_codec_9

Overview:
- Crosstalk-avoidance codec for a 9-wire TSV bundle: a registered encoder plus a combinational decoder.
- Encoder maps a 6-bit data word onto a 9-bit forbidden-transition-free codeword. Decoder recovers the data word from a 9-bit codeword.
- Codewords follow a local Fibonacci-numeral-system ordering.
- Sits between the core data path and the TSV drivers/receivers. Encoder output drives the TSVs; decoder input is fed from the TSV receivers.

Parameters:
- DATA_W, 6: data width. Fixed; equals floor(log2(89)), where 89 is the number of valid 9-bit codewords.
- TSV_W, 9: codeword width, i.e. the number of TSV wires. Fixed.

Ports:
- clock  in  1  rising-edge clock for the encoder register.
- reset  in  1  asynchronous, active-high reset.
- datain  in  6  data word to encode.
- tsv  out  9  registered encoded codeword to the TSV drivers.
- tsv_in  in  9  received codeword to decode; may be tied to tsv for loopback.
- dataout  out  6  decoded data word (combinational from tsv_in).
- code_err  out  1  codeword error flag; present only with CAC_CODE_CHK_EN.

Behaviour:
- Valid codeword: for each odd bit i in {1,3,5,7}, tsv[i]=1 only if tsv[i-1]=1 and tsv[i+1]=1.
  - Equivalently, no pattern 0-1-x or x-1-0 centred on an odd wire.
  - Even bits are unconstrained.
  - Exactly 89 valid words exist.
- Code ordering: sort the 89 valid words ascending as unsigned 9-bit numbers. Data value k maps to the k-th word (0-based). The encoding is strictly monotonic.
- Encoder:
  - On every rising clock edge, tsv <= codeword(datain). Latency is one cycle; there is no enable.
  - All 64 datain values are legal, and every resulting tsv value is valid.
- Reset: while reset is high, tsv = 9'b000000000 (codeword of 0), held immediately and asynchronously. The first capture occurs on the first rising edge after reset deasserts.
- Decoder:
  - Purely combinational. dataout = number of valid codewords strictly less than tsv_in (unsigned), truncated to 6 bits.
  - For a valid input this is its exact rank.
  - For an invalid input the same counting rule applies, so the output is deterministic and contains no X.
  - dataout does not depend on clock or reset.
- Implementation: weighted-digit sum / greedy subtraction over the 9 positions. Weight tables are derived from the counts of valid prefixes: 2, 2, 5, 5, 13, 13, 34, 34, 89 valid words below 2^1 through 2^9 respectively. ROM-free logic is preferred.
- Reference points:
  - rank 0 = 000000000
  - rank 2 = 000000100
  - rank 4 = 000000111
  - rank 5 = 000010000
  - rank 13 = 001000000
  - rank 34 = 100000000
  - rank 63 = 101110101
- Round trip: encode then decode is the identity for all 64 data values, with one cycle of latency through the encoder register.

Optional Feature:
- Macro: CAC_CODE_CHK_EN.
- Defined:
  - Adds output code_err (1 bit, combinational).
  - code_err=1 when tsv_in violates the odd-wire rule, or when its rank is greater than 63 (the rank is unrepresentable in 6 bits).
  - dataout is unchanged.
- Undefined: port code_err does not exist and no checking logic is built.

Test Plan:
- Reset: assert reset with datain=6'd37 -> tsv=000000000 immediately, and stays there while reset is high. Deassert reset, apply one rising edge -> tsv=codeword(37).
- Sweep: apply datain=0..63 with one edge each, loopback tsv_in=tsv. After each edge:
  - dataout equals datain.
  - tsv has no odd bit at 1 with a 0 neighbour.
  - tsv values are strictly increasing across the sweep.
- Fixed vectors:
  - datain=0 -> 000000000
  - datain=1 -> 000000001
  - datain=2 -> 000000100
  - datain=5 -> 000010000
  - datain=13 -> 001000000
  - datain=34 -> 100000000
  - datain=63 -> 101110101
- Latency: change datain between edges -> tsv changes only at the next rising edge. dataout follows tsv_in combinationally.
- Decoder on invalid input:
  - tsv_in=000000010 -> dataout=2; with CAC_CODE_CHK_EN, code_err=1.
  - tsv_in=111111111 -> dataout=88 mod 64=24; with CAC_CODE_CHK_EN, code_err=1 (rank > 63).
- Error flag clean: every valid codeword of rank 0..63 applied to tsv_in -> code_err=0.
